wb_line_responder: RTL and testbench

Memory-side responder for the cache's line-granular strobe/cycle memory interface (`mem_action_stb`, `mem_action_cyc`, `mem_write`, `mem_resp`, `mem_retry`). It accepts one full-line read or write at a time from the cache controller. It completes the access after a fixed, parameterised latency and pulses `mem_resp` for one cycle. It sits between the cache eviction/write-back controller and the line-organised backing store, and doubles as the physical-memory model in cache benches.

---
 rtl/wb_mem_pkg.sv | 29 ++
 rtl/line_ram.sv | 30 +++
 rtl/wb_line_responder.sv | 154 +++++++++++++++
 tb/tb_wb_line_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and geometry helpers for the line-granular memory interface.
// Both the cache controller and the memory-side responder import this package.
package wb_mem_pkg;

  // Default line width used by the shared line type.
  localparam int unsigned LINE_WIDTH_DEF = 256;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } wb_resp_state_t;

  // One full cache line.
  typedef logic [LINE_WIDTH_DEF-1:0] line_t;

  // Number of byte-offset bits inside one line.
  function automatic int unsigned ofs_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  // Number of line-index bits for a store of the given depth (depth >= 2).
  function automatic int unsigned idx_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_WIDTH line store: one synchronous write port and an
// asynchronous read port whose output is registered by the responder.
module line_ram
  import wb_mem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int LINE_WIDTH = 256,
  parameter int IDX_W      = idx_bits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  // Storage is deliberately not reset: never-written lines read as undefined.
  logic [LINE_WIDTH-1:0] mem_q [DEPTH];

  // Commit one full line on the write strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_line_responder.sv
// Memory-side responder: accepts one full-line read or write at a time,
// completes it after LATENCY cycles with a one-cycle mem_resp pulse, then
// spends one dead RECOVER cycle so a held strobe is not re-accepted at once.
//
// Handshake: a request is present while mem_action_stb & mem_action_cyc are
// both high. It is accepted in IDLE, must stay present through BUSY (dropping
// it aborts with no side effects), and is answered by mem_resp for exactly one
// cycle. mem_retry = req & ~mem_resp tells the master to keep waiting.
module wb_line_responder
  import wb_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_action_stb,
  input  logic                  mem_action_cyc,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [LINE_WIDTH-1:0] mem_wdata,
  output logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  mem_resp,
  output logic                  mem_retry,
  output logic [1:0]            dbg_state
);

  localparam int OFS   = ofs_bits(LINE_WIDTH);
  localparam int IDX   = idx_bits(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  wb_resp_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [IDX-1:0]        idx_q, idx_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

  logic                  req;
  logic [IDX-1:0]        req_idx;
  logic                  ram_we;
  logic [IDX-1:0]        ram_raddr;
  logic [LINE_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

  assign req     = mem_action_stb & mem_action_cyc;
  // Offset bits and bits above the index are ignored, so addresses alias.
  assign req_idx = mem_address[OFS +: IDX];
  assign unused_addr = ^mem_address;

  line_ram #(
    .DEPTH      (DEPTH),
    .LINE_WIDTH (LINE_WIDTH),
    .IDX_W      (IDX)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Next-state, latch and array-control decode for the responder FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_raddr = idx_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = mem_write;
          idx_d   = req_idx;
          wdata_d = mem_wdata;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            // No BUSY phase: the index is not latched yet, so read the
            // array with the incoming index on the edge entering RESP.
            state_d   = RESP;
            ram_raddr = req_idx;
            if (!mem_write) begin
              rdata_d = ram_rdata;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // Abort: nothing is committed and mem_rdata keeps its value.
          state_d = IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          if (!wr_q) begin
            rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        // Write commits on the edge ending RESP, unless reset is in flight.
        ram_we  = wr_q & ~rst;
        state_d = RECOVER;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and read-data registers; reset overrides every event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
    end
  end

  // Latched write data needs no reset: it is only used after an acceptance.
  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

  assign mem_rdata = rdata_q;
  assign mem_resp  = (state_q == RESP);
  assign mem_retry = req & ~mem_resp;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_line_responder.sv
// Directed bench for wb_line_responder: reset, write timing, read-back with
// address aliasing, abort, held strobe across RECOVER, reset mid-transaction.
module tb_wb_line_responder;
  import wb_mem_pkg::*;

  localparam logic [255:0] DEAD  = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] PAT_A = {8{32'h0123_4567}};
  localparam logic [255:0] PAT_B = {8{32'hCAFE_F00D}};
  localparam logic [255:0] ZERO  = '0;
  localparam logic [255:0] ONES  = '1;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         stb;
  logic         cyc;
  logic         we;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic [255:0] rdata;
  logic         resp;
  logic         retry;
  logic [1:0]   st;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_line_responder #(
    .ADDR_WIDTH (32),
    .LINE_WIDTH (256),
    .DEPTH      (64),
    .LATENCY    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_action_stb (stb),
    .mem_action_cyc (cyc),
    .mem_write      (we),
    .mem_address    (addr),
    .mem_wdata      (wdata),
    .mem_rdata      (rdata),
    .mem_resp       (resp),
    .mem_retry      (retry),
    .dbg_state      (st)
  );

  // ---------------- check helpers ----------------
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input wb_resp_state_t exp);
    checks++;
    assert (obs === 2'(exp)) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, 2'(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move to the next cycle: inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access from acceptance in the current cycle (cycle 0) to the
  // first IDLE cycle after RECOVER. Address and data are scrambled during BUSY
  // to show the latched copy is what gets used.
  task automatic access(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] exp_rd, input string tag);
    stb = 1'b1; cyc = 1'b1; we = w; addr = a; wdata = d;
    #1;
    check_bit({tag, "_c0_retry"}, retry, 1'b1);
    check_bit({tag, "_c0_resp"}, resp, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      addr  = a ^ 32'h0000_0FE0;
      wdata = ~d;
      #1;
      check_bit({tag, "_busy_retry"}, retry, 1'b1);
      check_bit({tag, "_busy_resp"}, resp, 1'b0);
      check_st({tag, "_busy_state"}, st, BUSY);
    end
    tick();
    #1;
    check_bit({tag, "_c4_resp"}, resp, 1'b1);
    check_bit({tag, "_c4_retry"}, retry, 1'b0);
    check_line({tag, "_c4_rdata"}, rdata, exp_rd);
    tick();
    stb = 1'b0; cyc = 1'b0;
    #1;
    check_bit({tag, "_c5_resp"}, resp, 1'b0);
    check_bit({tag, "_c5_retry"}, retry, 1'b0);
    check_st({tag, "_c5_state"}, st, RECOVER);
    tick();
    #1;
    check_st({tag, "_c6_state"}, st, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // 1. Reset
    tick();
    tick();
    #1;
    check_bit("rst_resp", resp, 1'b0);
    check_bit("rst_retry", retry, 1'b0);
    check_line("rst_rdata", rdata, ZERO);
    check_st("rst_state", st, IDLE);
    rst = 1'b0;
    tick();

    // 2. Write timing
    access(1'b1, 32'h0000_0040, DEAD, ZERO, "wr40");

    // 3. Read-back and aliasing onto index 2
    access(1'b0, 32'h0000_0040, ZERO, DEAD, "rd40");
    access(1'b0, 32'h0000_005F, ZERO, DEAD, "rd5f");
    access(1'b0, 32'h0000_0840, ZERO, DEAD, "rd840");

    // 4. Abort: line 0x80 first holds zeros, then an aborted all-ones write
    access(1'b1, 32'h0000_0080, ZERO, DEAD, "wr80");
    stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = 32'h0000_0080; wdata = ONES;
    #1;
    check_bit("abort_c0_retry", retry, 1'b1);
    tick();
    #1;
    check_st("abort_c1_state", st, BUSY);
    tick();
    stb = 1'b0; cyc = 1'b0;
    #1;
    check_bit("abort_c2_resp", resp, 1'b0);
    check_bit("abort_c2_retry", retry, 1'b0);
    tick();
    #1;
    check_st("abort_c3_state", st, IDLE);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check_bit("abort_noresp", resp, 1'b0);
      check_line("abort_rdata_hold", rdata, DEAD);
    end
    access(1'b0, 32'h0000_0080, ZERO, ZERO, "rd80");

    // 5. Held strobe: write 0xC0, keep req high into a read of 0xC0
    stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = 32'h0000_00C0; wdata = PAT_A;
    #1;
    check_bit("held_c0_retry", retry, 1'b1);
    repeat (3) tick();
    tick();
    #1;
    check_bit("held_c4_resp", resp, 1'b1);
    check_line("held_c4_rdata", rdata, ZERO);
    tick();
    we = 1'b0; addr = 32'h0000_00C0; wdata = ZERO;
    #1;
    check_st("held_c5_state", st, RECOVER);
    check_bit("held_c5_retry", retry, 1'b1);
    check_bit("held_c5_resp", resp, 1'b0);
    tick();
    #1;
    check_st("held_c6_state", st, IDLE);
    check_bit("held_c6_retry", retry, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1;
      check_bit("held_busy_resp", resp, 1'b0);
      check_st("held_busy_state", st, BUSY);
    end
    tick();
    #1;
    check_bit("held_c10_resp", resp, 1'b1);
    check_line("held_c10_rdata", rdata, PAT_A);
    tick();
    stb = 1'b0; cyc = 1'b0;
    #1;
    check_st("held_c11_state", st, RECOVER);
    check_bit("held_c11_resp", resp, 1'b0);
    tick();

    // 6. Reset mid-transaction during BUSY of a write to 0xC0
    stb = 1'b1; cyc = 1'b1; we = 1'b1; addr = 32'h0000_00C0; wdata = PAT_B;
    #1;
    tick();
    #1;
    check_st("rstmid_c1_state", st, BUSY);
    tick();
    rst = 1'b1;
    #1;
    check_st("rstmid_c2_state", st, BUSY);
    tick();
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    #1;
    check_st("rstmid_c3_state", st, IDLE);
    check_bit("rstmid_c3_resp", resp, 1'b0);
    check_line("rstmid_c3_rdata", rdata, ZERO);
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      check_bit("rstmid_noresp", resp, 1'b0);
    end
    access(1'b0, 32'h0000_00C0, ZERO, PAT_A, "rdc0");

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
